sopc_run_ctrl: RTL and testbench

Synthesizable run controller that sits between the board clock/reset pins and the SOPC cores. It turns a raw asynchronous reset into per-domain synchronous resets, held for a programmable time and released in a staggered order. It then counts run cycles and freezes the system on a halt request or when a cycle budget is exhausted. A software reset request re-runs the hold/release sequence without a board reset.

---
 rtl/sopc_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_sopc_run_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sopc_run_ctrl.sv
// Run controller: async board reset -> staggered per-domain sync resets, then run-cycle count with halt/budget freeze.
// Latency: HOLD at 3rd edge after rst_n rises; domain i released HOLD_CYCLES+i*STAGGER edges later; all outputs registered.
// Backpressure: none; soft_rst_req > halt_req > run budget, evaluated every edge.
module sopc_run_ctrl #(
    parameter int N_DOM       = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 32,
    parameter int RUN_LIMIT   = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst_req,
    input  logic             halt_req,
    output logic [N_DOM-1:0] dom_rst,
    output logic             clk_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int REL_MAX = (N_DOM - 1) * STAGGER;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         rst_sync;
    logic               sync_rel;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [REL_W-1:0]   rel_cnt, rel_nxt, rel_inc;
    logic [N_DOM-1:0]   dom_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               run_limit_hit;

    // Deassertion of rst_n becomes visible to the FSM two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign sync_rel      = rst_sync[1];
    assign rel_inc       = rel_cnt + REL_W'(1);
    assign run_limit_hit = (RUN_LIMIT != 0) && (cycle_cnt == CNT_W'(RUN_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            hold_cnt  <= '0;
            rel_cnt   <= '0;
            dom_rst   <= '1;
            clk_en    <= 1'b1;
            running   <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            rel_cnt   <= rel_nxt;
            dom_rst   <= dom_nxt;
            clk_en    <= (state_nxt != ST_HALT);
            running   <= (state_nxt == ST_RUN);
            halted    <= (state_nxt == ST_HALT);
            cycle_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        rel_nxt   = rel_cnt;
        dom_nxt   = dom_rst;
        cnt_nxt   = cycle_cnt;

        case (state)
            ST_RESET: begin
                hold_nxt = '0;
                rel_nxt  = '0;
                if (sync_rel) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_nxt  = ST_RELEASE;
                    rel_nxt    = '0;
                    dom_nxt[0] = 1'b0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (rel_cnt == REL_W'(REL_MAX)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    rel_nxt = rel_inc;
                    // Domain i drops its reset on the edge where rel_cnt lands on i*STAGGER.
                    for (int i = 1; i < N_DOM; i++) begin
                        if (int'(rel_inc) == i * STAGGER) begin
                            dom_nxt[i] = 1'b0;
                        end
                    end
                end
            end
            ST_RUN: begin
                cnt_nxt = cycle_cnt + CNT_W'(1);
                if (halt_req || run_limit_hit) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_RESET;
                dom_nxt   = '1;
                cnt_nxt   = '0;
            end
        endcase

        // Software reset restarts the hold/release sequence from any post-reset state.
        if (soft_rst_req && (state != ST_RESET)) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            rel_nxt   = '0;
            dom_nxt   = '1;
            cnt_nxt   = '0;
        end
    end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: N_DOM=3, HOLD_CYCLES=4, STAGGER=2; instance a has RUN_LIMIT=8, instance b RUN_LIMIT=0 with a 4-bit counter.
// Expected outputs per edge are queued when a scenario starts and compared on the following falling edge.
module tb_sopc_run_ctrl;

    localparam int N_DOM   = 3;
    localparam int HOLD    = 4;
    localparam int STAG    = 2;
    localparam int LIMIT   = 8;
    localparam int RUN_H   = HOLD + (N_DOM - 1) * STAG + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             soft_a, halt_a, soft_b, halt_b;
    logic [N_DOM-1:0] dom_a, dom_b;
    logic             ce_a, run_a, hlt_a, ce_b, run_b, hlt_b;
    logic [31:0]      cnt_a;
    logic [3:0]       cnt_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int e0       = 0;

    typedef struct {
        int          edge_no;
        bit          dut_b;
        string       tag;
        logic [2:0]  dom;
        logic        ce;
        logic        run;
        logic        hlt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    sopc_run_ctrl #(.N_DOM(N_DOM), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .CNT_W(32), .RUN_LIMIT(LIMIT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_a), .halt_req(halt_a),
        .dom_rst(dom_a), .clk_en(ce_a), .running(run_a), .halted(hlt_a), .cycle_cnt(cnt_a)
    );

    sopc_run_ctrl #(.N_DOM(N_DOM), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .CNT_W(4), .RUN_LIMIT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_b), .halt_req(halt_b),
        .dom_rst(dom_b), .clk_en(ce_b), .running(run_b), .halted(hlt_b), .cycle_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push(input int e, input bit b, input string tag, input logic [2:0] dom,
                                 input logic ce, input logic run, input logic hlt, input logic [31:0] cnt);
        exp_t x;
        x.edge_no = e; x.dut_b = b; x.tag = tag; x.dom = dom;
        x.ce = ce; x.run = run; x.hlt = hlt; x.cnt = cnt;
        sb.push_back(x);
    endfunction

    // Expected instance-a outputs h edges after HOLD entry (h<0: still in reset), halting at h=halt_h.
    function automatic void push_seq(input int e_hold, input int from_h, input int to_h,
                                     input int halt_h, input string tag);
        for (int h = from_h; h <= to_h; h++) begin
            logic [2:0]  dom;
            logic [31:0] cnt;
            for (int i = 0; i < N_DOM; i++) dom[i] = (h < HOLD + i * STAG);
            if (h < RUN_H)        cnt = 0;
            else if (h < halt_h)  cnt = 32'(h - RUN_H);
            else                  cnt = 32'(halt_h - RUN_H);
            push(e_hold + h, 1'b0, $sformatf("%s_h%0d", tag, h), dom,
                 h < halt_h, (h >= RUN_H) && (h < halt_h), h >= halt_h, cnt);
        end
    endfunction

    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].edge_no == cyc) begin
                if (sb[i].dut_b) begin
                    chk({sb[i].tag, "_dom"}, 32'(dom_b), 32'(sb[i].dom));
                    chk({sb[i].tag, "_ce"},  32'(ce_b),  32'(sb[i].ce));
                    chk({sb[i].tag, "_run"}, 32'(run_b), 32'(sb[i].run));
                    chk({sb[i].tag, "_hlt"}, 32'(hlt_b), 32'(sb[i].hlt));
                    chk({sb[i].tag, "_cnt"}, 32'(cnt_b), sb[i].cnt);
                end else begin
                    chk({sb[i].tag, "_dom"}, 32'(dom_a), 32'(sb[i].dom));
                    chk({sb[i].tag, "_ce"},  32'(ce_a),  32'(sb[i].ce));
                    chk({sb[i].tag, "_run"}, 32'(run_a), 32'(sb[i].run));
                    chk({sb[i].tag, "_hlt"}, 32'(hlt_a), 32'(sb[i].hlt));
                    chk({sb[i].tag, "_cnt"}, cnt_a,      sb[i].cnt);
                end
            end else if (sb[i].edge_no < cyc) begin
                chk({sb[i].tag, "_late"}, 32'(cyc), 32'(sb[i].edge_no));
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic wait_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves rst_n released just after edge E0 (recorded in e0).
    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        e0    = cyc;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n  = 1'b1;
        soft_a = 1'b0; halt_a = 1'b0;
        soft_b = 1'b0; halt_b = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dom",   32'(dom_a), 32'h7);
        chk("rst_ce",    32'(ce_a),  32'h1);
        chk("rst_run",   32'(run_a), 32'h0);
        chk("rst_hlt",   32'(hlt_a), 32'h0);
        chk("rst_cnt",   cnt_a,      32'h0);
        chk("rst_cnt_b", 32'(cnt_b), 32'h0);

        // Power-up, auto-halt at E20, frozen through E40; instance b wraps 15->0 at E28.
        do_reset();
        push_seq(e0 + 3, -2, 37, RUN_H + LIMIT, "pwr");
        push(e0 + 12, 1'b1, "wrap_e12", 3'b000, 1'b1, 1'b1, 1'b0, 32'd0);
        push(e0 + 27, 1'b1, "wrap_e27", 3'b000, 1'b1, 1'b1, 1'b0, 32'd15);
        push(e0 + 28, 1'b1, "wrap_e28", 3'b000, 1'b1, 1'b1, 1'b0, 32'd0);
        push(e0 + 40, 1'b1, "wrap_e40", 3'b000, 1'b1, 1'b1, 1'b0, 32'd12);
        wait_to(e0 + 41);

        // halt_req raised after E15 (sampled at E16), second pulse ignored.
        do_reset();
        push_seq(e0 + 3, 8, 22, 13, "hreq");
        wait_to(e0 + 15); halt_a = 1'b1;
        wait_to(e0 + 16); halt_a = 1'b0;
        wait_to(e0 + 20); halt_a = 1'b1;
        wait_to(e0 + 21); halt_a = 1'b0;
        wait_to(e0 + 26);

        // Soft reset out of HALT, sampled at E25.
        do_reset();
        push_seq(e0 + 3, 15, 21, RUN_H + LIMIT, "ahlt");
        push_seq(e0 + 25, 0, 11, RUN_H + LIMIT, "soft");
        wait_to(e0 + 24); soft_a = 1'b1;
        wait_to(e0 + 25); soft_a = 1'b0;
        wait_to(e0 + 37);

        // rst_n dropped between E8 and E9 in RELEASE, then full re-run.
        do_reset();
        push_seq(e0 + 3, 2, 5, RUN_H + LIMIT, "rel");
        wait_to(e0 + 8);
        #5 rst_n = 1'b0;
        #1;
        chk("async_dom", 32'(dom_a), 32'h7);
        chk("async_ce",  32'(ce_a),  32'h1);
        chk("async_run", 32'(run_a), 32'h0);
        chk("async_hlt", 32'(hlt_a), 32'h0);
        chk("async_cnt", cnt_a,      32'h0);
        do_reset();
        push_seq(e0 + 3, -2, 11, RUN_H + LIMIT, "rerun");
        wait_to(e0 + 15);

        // soft_rst_req and halt_req together at E14: soft reset wins.
        do_reset();
        push_seq(e0 + 3, 8, 10, RUN_H + LIMIT, "pre");
        push_seq(e0 + 14, 0, 10, RUN_H + LIMIT, "both");
        wait_to(e0 + 13); soft_a = 1'b1; halt_a = 1'b1;
        wait_to(e0 + 14); soft_a = 1'b0; halt_a = 1'b0;
        wait_to(e0 + 26);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
